phj_result_compactor: RTL and testbench

- Consumes the sparse 1024-bit result stream from the partitioned hash join output: 8 lanes of 128-bit joined tuples, with 16 byte-enables per lane in out_keep.
- Packs the valid tuples densely into 512-bit beats of 4 tuples each, for host write-back.
- Preserves tuple order and propagates end-of-batch.
- Sits between the join top-level output and the host/DMA write stream.

---
 rtl/phj_result_compactor.sv | 132 +++++++++++++
 tb/tb_phj_result_compactor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phj_result_compactor.sv
// Packs the sparse 8-lane join result stream into dense 4-lane beats for host
// write-back, preserving tuple order and the end-of-batch marker.
module phj_result_compactor #(
    parameter int IN_LANES  = 8,
    parameter int OUT_LANES = 4,
    parameter int LANE_BITS = 128,
    parameter int BUF_SLOTS = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [IN_LANES*LANE_BITS-1:0]   in_data,
    input  logic [IN_LANES*LANE_BITS/8-1:0] in_keep,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [OUT_LANES*LANE_BITS-1:0]  out_data,
    output logic [OUT_LANES*LANE_BITS/8-1:0] out_keep,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [31:0]                     tuple_count,
    output logic                            keep_error
);

    localparam int KB    = LANE_BITS / 8;
    localparam int CNT_W = $clog2(BUF_SLOTS + OUT_LANES + 1);

    logic [LANE_BITS-1:0] buf_q [BUF_SLOTS];
    logic [LANE_BITS-1:0] buf_d [BUF_SLOTS];
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic                 last_pend_q, last_pend_d;
    logic [31:0]          count_q;
    logic                 keep_err_q;

    logic [IN_LANES-1:0]  lane_vld;
    logic [IN_LANES-1:0]  lane_bad;
    logic [CNT_W-1:0]     emit;
    logic [CNT_W-1:0]     pop_n;
    logic [CNT_W-1:0]     src;
    logic [CNT_W-1:0]     wr;
    logic                 accept;
    logic                 pop;

    // A partially enabled lane is malformed: flag it and drop it rather than
    // forwarding a tuple with missing bytes.
    always_comb begin
        lane_vld = '0;
        lane_bad = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            lane_vld[i] = &in_keep[i*KB +: KB];
            lane_bad[i] = (|in_keep[i*KB +: KB]) && !(&in_keep[i*KB +: KB]);
        end
    end

    always_comb begin
        emit = '0;
        if (!reset) begin
            emit = (occ_q >= CNT_W'(OUT_LANES)) ? CNT_W'(OUT_LANES) : occ_q;
        end
        out_valid = !reset && ((occ_q >= CNT_W'(OUT_LANES)) || last_pend_q);
        out_last  = !reset && last_pend_q && (occ_q <= CNT_W'(OUT_LANES));
        in_ready  = !reset && !last_pend_q && (occ_q < CNT_W'(OUT_LANES));
        out_data  = '0;
        out_keep  = '0;
        for (int k = 0; k < OUT_LANES; k++) begin
            if (CNT_W'(k) < emit) begin
                out_data[k*LANE_BITS +: LANE_BITS] = buf_q[k];
                out_keep[k*KB +: KB]               = '1;
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign pop_n  = pop ? emit : '0;

    // Shift out the popped lanes, then append the valid input lanes in order
    // behind whatever remains.
    always_comb begin
        src = '0;
        for (int j = 0; j < BUF_SLOTS; j++) begin
            src = CNT_W'(j) + pop_n;
            if (src < CNT_W'(BUF_SLOTS)) begin
                buf_d[j] = buf_q[src];
            end else begin
                buf_d[j] = buf_q[j];
            end
        end
        wr = occ_q - pop_n;
        for (int i = 0; i < IN_LANES; i++) begin
            if (accept && lane_vld[i]) begin
                if (wr < CNT_W'(BUF_SLOTS)) begin
                    buf_d[wr] = in_data[i*LANE_BITS +: LANE_BITS];
                end
                wr = wr + 1'b1;
            end
        end
        occ_d = wr;

        last_pend_d = last_pend_q;
        if (pop && out_last) begin
            last_pend_d = 1'b0;
        end
        if (accept && in_last) begin
            last_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q       <= '0;
            last_pend_q <= 1'b0;
            count_q     <= '0;
            keep_err_q  <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            last_pend_q <= last_pend_d;
            count_q     <= count_q + 32'(pop_n);
            if (accept && (|lane_bad)) begin
                keep_err_q <= 1'b1;
            end
        end
    end

    assign tuple_count = count_q;
    assign keep_error  = keep_err_q;

endmodule

// File: tb/tb_phj_result_compactor.sv
// Directed bench for phj_result_compactor: batch table plus hand sequences for
// backpressure, malformed keep and mid-batch reset.
module tb_phj_result_compactor;

    logic          clk = 1'b0;
    logic          reset;
    logic [1023:0] in_data;
    logic [127:0]  in_keep;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [511:0]  out_data;
    logic [63:0]   out_keep;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [31:0]   tuple_count;
    logic          keep_error;

    always #5 clk = ~clk;

    phj_result_compactor dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready),
        .tuple_count(tuple_count), .keep_error(keep_error)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [511:0] obs_data [$];
    logic [63:0]  obs_keep [$];
    logic         obs_last [$];
    int           n_last = 0;
    int           last_base = 0;

    logic [127:0] exp_q [$];
    int unsigned  exp_count = 0;

    typedef struct {
        logic [7:0]  mask;
        int          beats;
        logic [63:0] last_keep;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_keep.push_back(out_keep);
            obs_last.push_back(out_last);
            if (out_last) n_last++;
        end
    end

    function automatic logic [127:0] tup(input int b, input int l);
        return {32'(b), 32'(l), ~32'(b), 32'hC0DE0000 | 32'(l)};
    endfunction

    task automatic send_raw(input logic [1023:0] d, input logic [127:0] k, input logic l);
        int cyc = 0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            #1;
            if (in_ready) break;
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                n_chk++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", cyc);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_mask(input int b, input logic [7:0] m, input logic l);
        logic [1023:0] d;
        logic [127:0]  k;
        for (int i = 0; i < 8; i++) begin
            d[i*128 +: 128] = tup(b, i);
            k[i*16 +: 16]   = m[i] ? 16'hFFFF : 16'h0000;
            if (m[i]) begin
                exp_q.push_back(tup(b, i));
                exp_count++;
            end
        end
        send_raw(d, k, l);
    endtask

    task automatic begin_batch();
        obs_data.delete();
        obs_keep.delete();
        obs_last.delete();
        last_base = n_last;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (n_last == last_base && cyc < 400) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        if (n_last == last_base) begin
            n_chk++;
            $display("FAIL %s_timeout: no out_last after %0d cycles, required one", name, cyc);
        end
        @(negedge clk);
    endtask

    task automatic check_batch(input string name, input int beats, input logic [63:0] lk);
        logic [127:0] act [$];
        int           pad_bad = 0;
        int           nl = 0;
        logic         ok;
        logic [63:0]  got_lk;
        logic         got_ll;
        got_lk = (obs_keep.size() > 0) ? obs_keep[obs_keep.size()-1] : 64'hx;
        got_ll = (obs_last.size() > 0) ? obs_last[obs_last.size()-1] : 1'bx;
        for (int b = 0; b < obs_data.size(); b++) begin
            if (obs_last[b]) nl++;
            for (int k = 0; k < 4; k++) begin
                if (obs_keep[b][k*16]) act.push_back(obs_data[b][k*128 +: 128]);
                else if (obs_data[b][k*128 +: 128] != 128'h0) pad_bad++;
            end
        end
        ok = (act.size() == exp_q.size());
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            if (act[i] !== exp_q[i]) ok = 1'b0;
        end
        chk({name, "_beats"}, 64'(obs_data.size()), 64'(beats));
        chk({name, "_lastkeep"}, got_lk, lk);
        chk({name, "_lastflag"}, 64'(got_ll), 64'd1);
        chk({name, "_lastcnt"}, 64'(nl), 64'd1);
        chk({name, "_order"}, 64'(ok), 64'd1);
        chk({name, "_pad"}, 64'(pad_bad), 64'd0);
        chk({name, "_count"}, 64'(tuple_count), 64'(exp_count));
        exp_q.delete();
    endtask

    vec_t vecs [6];

    initial begin
        logic [1023:0] d;
        logic [127:0]  k;
        logic [511:0]  snap;
        int            unstable;

        vecs[0] = '{8'hFF, 2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{8'h4A, 1, 64'h0000_FFFF_FFFF_FFFF};
        vecs[2] = '{8'h00, 1, 64'h0000_0000_0000_0000};
        vecs[3] = '{8'h1F, 2, 64'h0000_0000_0000_FFFF};
        vecs[4] = '{8'h0F, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{8'h81, 1, 64'h0000_0000_FFFF_FFFF};

        reset = 1'b1; in_data = '0; in_keep = '0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_keep", out_keep, 64'd0);
        chk("rst_out_data", 64'(|out_data), 64'd0);
        chk("rst_count", 64'(tuple_count), 64'd0);
        chk("rst_keep_err", 64'(keep_error), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        begin_batch();
        send_mask(1, 8'hFF, 1'b0);
        send_mask(2, 8'hFF, 1'b1);
        wait_done("full");
        check_batch("full", 4, 64'hFFFF_FFFF_FFFF_FFFF);

        begin_batch();
        send_mask(3, 8'b0100_1010, 1'b0);
        send_mask(4, 8'b1000_0001, 1'b1);
        wait_done("sparse");
        chk("sparse_keep0", obs_keep[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check_batch("sparse", 2, 64'h0000_0000_0000_FFFF);

        for (int r = 0; r < 6; r++) begin
            begin_batch();
            send_mask(100 + r, vecs[r].mask, 1'b1);
            wait_done($sformatf("vec%0d", r));
            check_batch($sformatf("vec%0d", r), vecs[r].beats, vecs[r].last_keep);
        end

        begin_batch();
        d = '0; k = '0;
        for (int i = 0; i < 4; i++) begin
            d[i*128 +: 128] = tup(50, i);
            k[i*16 +: 16]   = (i == 2) ? 16'h00FF : 16'hFFFF;
            if (i != 2) begin
                exp_q.push_back(tup(50, i));
                exp_count++;
            end
        end
        send_raw(d, k, 1'b1);
        wait_done("malformed");
        chk("malformed_flag", 64'(keep_error), 64'd1);
        check_batch("malformed", 1, 64'h0000_FFFF_FFFF_FFFF);
        begin_batch();
        send_mask(51, 8'h0F, 1'b1);
        wait_done("after_bad");
        chk("sticky_flag", 64'(keep_error), 64'd1);
        check_batch("after_bad", 1, 64'hFFFF_FFFF_FFFF_FFFF);

        out_ready = 1'b0;
        begin_batch();
        fork
            begin
                send_mask(20, 8'hFF, 1'b0);
                send_mask(21, 8'hFF, 1'b1);
            end
        join_none
        repeat (3) @(negedge clk);
        #1;
        snap = out_data;
        unstable = 0;
        chk("bp_valid", 64'(out_valid), 64'd1);
        repeat (7) begin
            @(negedge clk);
            #1;
            if (out_data !== snap) unstable++;
        end
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_stable", 64'(unstable), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        wait_done("bp");
        check_batch("bp", 4, 64'hFFFF_FFFF_FFFF_FFFF);

        out_ready = 1'b0;
        begin_batch();
        send_mask(30, 8'h3F, 1'b0);
        exp_q.delete();
        exp_count = 0;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_count", 64'(tuple_count), 64'd0);
        chk("midrst_valid2", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_keep_err", 64'(keep_error), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        begin_batch();
        send_mask(31, 8'h33, 1'b1);
        wait_done("post_rst");
        check_batch("post_rst", 1, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
